warn_fluid_levels: RTL

//  Multi-channel low-level warning for dashboard fluids (engine oil, coolant, brake, washer).

---
 rtl/warn_fluid_levels_if.sv | 22 ++
 rtl/warn_fluid_levels.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/warn_fluid_levels_if.sv
// Bundles the sampled level bus, acknowledges and the lamp outputs of warn_fluid_levels.
// The sensor side holds the master modport; the warning block holds the slave modport.
interface warn_fluid_levels_if #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 32
);
  logic                    sample;
  logic [N_CH*WIDTH-1:0]   level;
  logic [N_CH-1:0]         ack;
  logic [N_CH-1:0]         warn;
  logic                    any_warn;

  modport master (
    output sample, level, ack,
    input  warn, any_warn
  );

  modport slave (
    input  sample, level, ack,
    output warn, any_warn
  );
endinterface

// File: rtl/warn_fluid_levels.sv
// Multi-channel low-fluid warning with hysteresis and debounce per channel.
// Define WARN_STICKY_EN to keep a cleared warning lit (HELD) until it is acknowledged.
module warn_fluid_levels #(
  parameter int N_CH     = 2,
  parameter int WIDTH    = 32,
  parameter int THRESH   = 10,
  parameter int HYST     = 5,
  parameter int DEBOUNCE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  warn_fluid_levels_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_C = CW'(DEBOUNCE);

  // Thresholds live in WIDTH+1 bits so THRESH+HYST can never wrap.
  localparam logic signed [WIDTH:0] THR_W = (WIDTH+1)'(THRESH);
  localparam logic signed [WIDTH:0] HYS_W = (WIDTH+1)'(HYST);
  localparam logic signed [WIDTH:0] HI_W  = THR_W + HYS_W;

`ifdef WARN_STICKY_EN
  typedef enum logic [2:0] {S_OK, S_ARMING, S_WARN, S_CLEARING, S_HELD} state_t;
  localparam state_t CLEAR_TGT = S_HELD;
`else
  typedef enum logic [2:0] {S_OK, S_ARMING, S_WARN, S_CLEARING} state_t;
  localparam state_t CLEAR_TGT = S_OK;
  logic unused_ack;
  assign unused_ack = ^bus.ack;
`endif

  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0] low;
  logic [N_CH-1:0] high;
  logic [N_CH-1:0] warn_d;
  logic [N_CH-1:0] warn_q;
  logic            any_q;

  always_comb begin
    low  = '0;
    high = '0;
    for (int i = 0; i < N_CH; i++) begin
      low[i]  = $signed({bus.level[i*WIDTH+WIDTH-1], bus.level[i*WIDTH +: WIDTH]}) < THR_W;
      high[i] = $signed({bus.level[i*WIDTH+WIDTH-1], bus.level[i*WIDTH +: WIDTH]}) >= HI_W;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_OK;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_OK: begin
          if (bus.sample && low[i]) begin
            if (DEBOUNCE == 1) begin
              state_d[i] = S_WARN;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = S_ARMING;
              cnt_d[i]   = CW'(1);
            end
          end
        end
        S_ARMING: begin
          if (bus.sample) begin
            if (!low[i]) begin
              state_d[i] = S_OK;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) == DB_C) begin
              state_d[i] = S_WARN;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CW'(1);
            end
          end
        end
        S_WARN: begin
          if (bus.sample && high[i]) begin
            if (DEBOUNCE == 1) begin
              state_d[i] = CLEAR_TGT;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = S_CLEARING;
              cnt_d[i]   = CW'(1);
            end
          end
        end
        S_CLEARING: begin
          if (bus.sample) begin
            if (!high[i]) begin
              state_d[i] = S_WARN;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) == DB_C) begin
              state_d[i] = CLEAR_TGT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CW'(1);
            end
          end
        end
`ifdef WARN_STICKY_EN
        // A fresh low sample outranks a simultaneous acknowledge.
        S_HELD: begin
          if (bus.sample && low[i]) begin
            state_d[i] = S_WARN;
            cnt_d[i]   = '0;
          end else if (bus.ack[i]) begin
            state_d[i] = S_OK;
            cnt_d[i]   = '0;
          end
        end
`endif
        default: begin
          state_d[i] = S_OK;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Lamps are decoded from the next state and registered, so they move on the accepting edge.
  always_comb begin
    warn_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      warn_d[i] = (state_d[i] == S_WARN) || (state_d[i] == S_CLEARING)
`ifdef WARN_STICKY_EN
                  || (state_d[i] == S_HELD)
`endif
                  ;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      warn_q <= '0;
      any_q  <= 1'b0;
    end else begin
      warn_q <= warn_d;
      any_q  <= |warn_d;
    end
  end

  assign bus.warn     = warn_q;
  assign bus.any_warn = any_q;

endmodule
